// File: rtl/button_pkg.sv
// Shared constants for the button debouncer: bank width and default timing.
package button_pkg;

  localparam int NUM_BUTTONS      = 8;
  localparam int DEF_CLK_FREQ     = 200_000_000;
  localparam int DEF_DEBOUNCE_HZ  = 1000;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_LONG_TICKS   = 1000;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Sample-tick divider: counts 0..TICK_DIV-1 and flags the terminal count for one cycle.
module tick_gen
  import button_pkg::*;
#(
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int DEBOUNCE_HZ = DEF_DEBOUNCE_HZ
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int TICK_DIV = CLK_FREQ / DEBOUNCE_HZ;
  localparam int CW       = cnt_width(TICK_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Eight-button debouncer with press/release pulses; long-press detection is built
// only when BUTTON_DEBOUNCE_LONGPRESS_EN is defined, otherwise long_press is tied low.
module button_debounce
  import button_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int DEBOUNCE_HZ  = DEF_DEBOUNCE_HZ,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] state,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] released,
  output logic [NUM_BUTTONS-1:0] long_press
);

  localparam int TICK_DIV = CLK_FREQ / DEBOUNCE_HZ;
  localparam int SW       = $clog2(STABLE_TICKS + 1);

  if (TICK_DIV < 2 || STABLE_TICKS < 2 || STABLE_TICKS > 255 || LONG_TICKS < 1) begin : g_bad_params
    $error("button_debounce: parameter out of range");
  end

  logic                   tick;
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;

  tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .DEBOUNCE_HZ(DEBOUNCE_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Raw levels are asynchronous; nothing downstream looks at buttons directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_bit
    logic [SW-1:0] stab_q, stab_d;
    logic          st_q, st_d;
    logic          pr_q, pr_d;
    logic          rl_q, rl_d;

    always_comb begin
      stab_d = '0;
      st_d   = st_q;
      pr_d   = 1'b0;
      rl_d   = 1'b0;
      if (sync2_q[gi] != st_q) begin
        stab_d = stab_q;
        if (tick) begin
          if (stab_q + SW'(1) == SW'(STABLE_TICKS)) begin
            stab_d = '0;
            st_d   = ~st_q;
            pr_d   = ~st_q;
            rl_d   = st_q;
          end else begin
            stab_d = stab_q + SW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stab_q <= '0;
        st_q   <= 1'b0;
        pr_q   <= 1'b0;
        rl_q   <= 1'b0;
      end else begin
        stab_q <= stab_d;
        st_q   <= st_d;
        pr_q   <= pr_d;
        rl_q   <= rl_d;
      end
    end

    assign state[gi]    = st_q;
    assign pressed[gi]  = pr_q;
    assign released[gi] = rl_q;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam int HW = cnt_width(LONG_TICKS);

    logic [HW-1:0] hold_q, hold_d;
    logic          lp_q, lp_d;

    // Saturates at LONG_TICKS so the event fires once per hold.
    always_comb begin
      hold_d = hold_q;
      lp_d   = 1'b0;
      if (!st_q) begin
        hold_d = '0;
      end else if (tick && hold_q != HW'(LONG_TICKS)) begin
        hold_d = hold_q + HW'(1);
        lp_d   = (hold_q + HW'(1) == HW'(LONG_TICKS));
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
        lp_q   <= 1'b0;
      end else begin
        hold_q <= hold_d;
        lp_q   <= lp_d;
      end
    end

    assign long_press[gi] = lp_q;
`else
    assign long_press[gi] = 1'b0;
`endif
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 200_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_HZ, default 1000, sample tick rate in Hz; TICK_DIV = CLK_FREQ/DEBOUNCE_HZ, TICK_DIV >= 2.
REQ-003 SHALL have parameter STABLE_TICKS, default 4, consecutive differing samples required to accept a change; range 2..255.
REQ-004 SHALL have parameter LONG_TICKS, default 1000, held-pressed samples before a long-press event; range >= 1.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port buttons, input, 8, raw asynchronous active-high button levels.
REQ-008 SHALL have port state, output, 8, debounced button levels.
REQ-009 SHALL have port pressed, output, 8, one-cycle pulse per bit on a debounced 0->1 transition.
REQ-010 SHALL have port released, output, 8, one-cycle pulse per bit on a debounced 1->0 transition.
REQ-011 SHALL have port long_press, output, 8, one-cycle pulse per bit on a long-press event.

Function
REQ-012 SHALL pass each buttons bit through a two-flop synchronizer before any other use.
REQ-013 SHALL generate tick: divider counts 0..TICK_DIV-1, wraps to 0; tick high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-014 SHALL keep, per bit, a stability counter sized $clog2(STABLE_TICKS+1) bits that clears in any cycle where the synchronized bit equals state.
REQ-015 SHALL, on tick with synchronized bit != state, increment the counter; when the increment reaches STABLE_TICKS, toggle state, clear the counter, and pulse pressed or released in the same cycle as the state update.
REQ-016 SHALL treat the 8 bits fully independently; simultaneous transitions on several bits produce simultaneous pulses.
REQ-017 SHALL reject any input excursion lasting fewer than STABLE_TICKS consecutive ticks, with no change to state and no pulse.
REQ-018 SHALL keep latency from a stable raw edge to the state change between (STABLE_TICKS-1)*TICK_DIV+3 and STABLE_TICKS*TICK_DIV+3 cycles.
REQ-019 SHALL never assert pressed and released on the same bit in the same cycle.

Reset
REQ-020 SHALL, with rst high at a clk edge, clear synchronizers, divider, stability and hold counters, state, pressed, released and long_press to 0.
REQ-021 SHALL, when a button is held through reset, assert pressed for that bit after normal debounce latency measured from rst deassertion.
REQ-022 SHALL abort any in-progress debounce or hold count on reset, with no pulse emitted.

Configuration
REQ-023 SHALL, with macro BUTTON_DEBOUNCE_LONGPRESS_EN defined, keep a per-bit hold counter that increments on tick while state is 1, pulses long_press once when it reaches LONG_TICKS, then saturates until release clears it.
REQ-024 SHALL, without BUTTON_DEBOUNCE_LONGPRESS_EN, keep the long_press port, tie it to 0, and instantiate no hold counters.

Structure
REQ-025 SHALL take NUM_BUTTONS (8) and the default timing constants from shared package button_pkg.
REQ-026 SHALL implement the tick divider as sub-module tick_gen (parameters CLK_FREQ and DEBOUNCE_HZ; ports clk, rst, tick).

Verification
Bench parameters: CLK_FREQ=1000, DEBOUNCE_HZ=100 (TICK_DIV=10), STABLE_TICKS=4, LONG_TICKS=8.
REQ-027 Reset: apply rst 3 cycles -> all outputs 0; first tick occurs exactly 10 cycles after rst release.
REQ-028 Clean press: buttons=0x01 held -> state[0] rises 33..43 cycles later, pressed=0x01 for exactly 1 cycle, released=0.
REQ-029 Bounce: buttons[3] high for 25 cycles then low -> state, pressed and released remain 0x00.
REQ-030 Simultaneous: buttons 0x00->0xA5 in one cycle -> pressed=0xA5 in a single cycle; then ->0x00 -> released=0xA5 in a single cycle.
REQ-031 Long press (macro defined): hold buttons[7] -> long_press=0x80 for one cycle 8 ticks after state[7] rises, no repeat; macro undefined -> long_press stays 0.
REQ-032 Reset mid-debounce: assert rst 2 ticks into a press -> no pulse; held button yields pressed 33..43 cycles after rst release.
